// File: rtl/register_write_scheduler_pkg.sv
// Shared types and defaults for the register-file write scheduler.
package register_write_scheduler_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned ADDR_WIDTH           = 5;
  localparam int unsigned NUM_REGS             = 2 ** ADDR_WIDTH;
  localparam int unsigned FIFO_DEPTH_DEFAULT   = 2;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  // One buffered long-latency result.
  typedef struct packed {
    reg_addr_t address;
    reg_data_t data;
  } lu_entry_t;

  localparam int unsigned LU_ENTRY_WIDTH = $bits(lu_entry_t);

  // DRAIN means the FIFO head owns the write port until the FIFO empties.
  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_DRAIN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/register_write_scheduler_if.sv
// Writeback, long-latency, decode and register-file signals of the write scheduler.
interface register_write_scheduler_if;
  import register_write_scheduler_pkg::*;

  logic      wb_valid;
  logic      wb_ready;
  reg_addr_t wb_address;
  reg_data_t wb_data;

  logic      lu_valid;
  logic      lu_ready;
  reg_addr_t lu_address;
  reg_data_t lu_data;

  logic      issue_valid;
  reg_addr_t issue_address;
  logic      issue_accept;

  reg_addr_t read_address_1;
  reg_addr_t read_address_2;
  reg_addr_t decode_dest_address;
  logic      raw_hazard_1;
  logic      raw_hazard_2;
  logic      waw_hazard;
  logic      stall_request;

  logic      rf_write_enable;
  reg_addr_t rf_write_address;
  reg_data_t rf_write_data;

  logic      fwd_valid_1;
  logic      fwd_valid_2;
  reg_data_t fwd_data_1;
  reg_data_t fwd_data_2;

  modport master (
    output wb_valid, wb_address, wb_data,
    output lu_valid, lu_address, lu_data,
    output issue_valid, issue_address,
    output read_address_1, read_address_2, decode_dest_address,
    input  wb_ready, lu_ready, issue_accept,
    input  raw_hazard_1, raw_hazard_2, waw_hazard, stall_request,
    input  rf_write_enable, rf_write_address, rf_write_data,
    input  fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2
  );

  modport slave (
    input  wb_valid, wb_address, wb_data,
    input  lu_valid, lu_address, lu_data,
    input  issue_valid, issue_address,
    input  read_address_1, read_address_2, decode_dest_address,
    output wb_ready, lu_ready, issue_accept,
    output raw_hazard_1, raw_hazard_2, waw_hazard, stall_request,
    output rf_write_enable, rf_write_address, rf_write_data,
    output fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2
  );

endinterface

// File: rtl/register_write_scheduler_write_result_fifo.sv
// Synchronous FIFO buffering long-latency results; DEPTH must be a power of two >= 2.
module register_write_scheduler_write_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count_q == COUNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/register_write_scheduler.sv
// Shares the register-file write port between writeback and buffered long-latency results.
// Define REGISTER_WRITE_FORWARD_EN to forward the in-flight write to the decode read ports.
module register_write_scheduler
  import register_write_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input logic                        system_clock,
  input logic                        system_reset_n,
  register_write_scheduler_if.slave  bus
);

  localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  lu_entry_t push_entry;
  lu_entry_t head;
  logic      fifo_push;
  logic      fifo_full;
  logic      fifo_empty;
  logic      stall;
  logic      head_commit;
  logic      issue_ok;
  logic      rf_we;
  reg_addr_t rf_addr;
  reg_data_t rf_data;

  assign push_entry = '{address: bus.lu_address, data: bus.lu_data};
  assign fifo_push  = bus.lu_valid && !fifo_full;

  register_write_scheduler_write_result_fifo #(
    .WIDTH (LU_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_write_result_fifo (
    .clk       (system_clock),
    .rst_n     (system_reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (head_commit),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port arbitration: wb wins unless draining; the head only uses idle wb cycles.
  always_comb begin
    stall       = (state_q == ARB_DRAIN);
    head_commit = !fifo_empty && (stall || !bus.wb_valid);
    rf_addr     = bus.wb_address;
    rf_data     = bus.wb_data;
    rf_we       = bus.wb_valid && (bus.wb_address != REG_ZERO);
    if (head_commit) begin
      rf_addr = head.address;
      rf_data = head.data;
      rf_we   = (head.address != REG_ZERO);
    end
  end

  assign issue_ok = bus.issue_valid &&
                    ((bus.issue_address == REG_ZERO) || !busy_q[bus.issue_address]);

  assign bus.wb_ready         = !stall || fifo_empty;
  assign bus.lu_ready         = !fifo_full;
  assign bus.issue_accept     = issue_ok;
  assign bus.stall_request    = stall;
  assign bus.rf_write_enable  = rf_we;
  assign bus.rf_write_address = rf_addr;
  assign bus.rf_write_data    = rf_data;

  assign bus.raw_hazard_1 = (bus.read_address_1 != REG_ZERO) && busy_q[bus.read_address_1];
  assign bus.raw_hazard_2 = (bus.read_address_2 != REG_ZERO) && busy_q[bus.read_address_2];
  assign bus.waw_hazard   = (bus.decode_dest_address != REG_ZERO) &&
                            busy_q[bus.decode_dest_address];

  // Next-state: scoreboard (set after clear so set wins), starvation counter, drain FSM.
  always_comb begin
    busy_d   = busy_q;
    starve_d = starve_q;
    state_d  = state_q;

    if (head_commit) busy_d[head.address] = 1'b0;
    if (issue_ok && (bus.issue_address != REG_ZERO)) busy_d[bus.issue_address] = 1'b1;

    if (fifo_empty || head_commit) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    case (state_q)
      ARB_NORMAL: if (starve_q == STARVE_MAX) state_d = ARB_DRAIN;
      ARB_DRAIN:  if (fifo_empty)             state_d = ARB_NORMAL;
      default:                                state_d = ARB_NORMAL;
    endcase
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  // Read-during-write forwarding; rf_we is already false for register 0.
  always_comb begin
    bus.fwd_valid_1 = 1'b0;
    bus.fwd_valid_2 = 1'b0;
    bus.fwd_data_1  = '0;
    bus.fwd_data_2  = '0;
`ifdef REGISTER_WRITE_FORWARD_EN
    if (rf_we && (rf_addr == bus.read_address_1)) begin
      bus.fwd_valid_1 = 1'b1;
      bus.fwd_data_1  = rf_data;
    end
    if (rf_we && (rf_addr == bus.read_address_2)) begin
      bus.fwd_valid_2 = 1'b1;
      bus.fwd_data_2  = rf_data;
    end
`else
    bus.fwd_valid_1 = 1'b0;
    bus.fwd_valid_2 = 1'b0;
`endif
  end

endmodule

// File: tb/tb_register_write_scheduler.sv
// Self-checking bench for register_write_scheduler: decode vector table, lu result scoreboard, corner sequences.
module tb_register_write_scheduler;
  import register_write_scheduler_pkg::*;

`ifdef REGISTER_WRITE_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic system_clock = 1'b0;
  logic system_reset_n;
  int   checks = 0;
  int   errors = 0;

  register_write_scheduler_if bus();

  register_write_scheduler dut (
    .system_clock   (system_clock),
    .system_reset_n (system_reset_n),
    .bus            (bus)
  );

  always #5 system_clock = ~system_clock;

  lu_entry_t lu_q[$];
  lu_entry_t mon_e;

  typedef struct {
    logic      iv;
    reg_addr_t ia;
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_addr_t dst;
    logic      acc;
    logic      raw1;
    logic      raw2;
    logic      waw;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid            = 1'b0;
    bus.wb_address          = '0;
    bus.wb_data             = '0;
    bus.lu_valid            = 1'b0;
    bus.lu_address          = '0;
    bus.lu_data             = '0;
    bus.issue_valid         = 1'b0;
    bus.issue_address       = '0;
    bus.read_address_1      = '0;
    bus.read_address_2      = '0;
    bus.decode_dest_address = '0;
  endtask

  // Drive an lu result; when acceptance is expected, queue the write it must later produce.
  task automatic lu_drive(input reg_addr_t a, input reg_data_t d, input bit accept_exp);
    bus.lu_valid   = 1'b1;
    bus.lu_address = a;
    bus.lu_data    = d;
    if (accept_exp && (a != REG_ZERO)) lu_q.push_back('{address: a, data: d});
  endtask

  // Every register-file write is either the granted wb request or the oldest queued lu result.
  always @(negedge system_clock) begin
    if (system_reset_n) begin
      if (bus.wb_valid && bus.wb_ready) begin
        check("sb_wb_we", bus.rf_write_enable, bus.wb_address != REG_ZERO);
        if (bus.wb_address != REG_ZERO) begin
          check("sb_wb_addr", bus.rf_write_address, bus.wb_address);
          check("sb_wb_data", bus.rf_write_data, bus.wb_data);
        end
      end else if (bus.rf_write_enable) begin
        if (lu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_write actual=%0h expected=none", bus.rf_write_address);
        end else begin
          mon_e = lu_q.pop_front();
          check("sb_lu_addr", bus.rf_write_address, mon_e.address);
          check("sb_lu_data", bus.rf_write_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic granted_prev;
    bit   found;

    //             iv    ia     ra1    ra2    dst    acc   raw1  raw2  waw
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd5,  5'd5,  5'd9,  5'd9,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd9,  5'd9,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 5'd9,  5'd9,  5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 5'd9,  5'd31, 5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 5'd31, 5'd9,  5'd31, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  5'd31, 5'd5,  5'd31, 1'b0, 1'b1, 1'b1, 1'b1};

    idle();
    system_reset_n = 1'b0;
    repeat (3) @(posedge system_clock);
    #2;
    check("rst_lu_ready", bus.lu_ready, 1);
    check("rst_rf_we", bus.rf_write_enable, 0);
    check("rst_stall", bus.stall_request, 0);
    check("rst_fwd_valid_2", bus.fwd_valid_2, 0);
    check("rst_fwd_data_2", bus.fwd_data_2, 0);
    system_reset_n = 1'b1;
    tick();
    #1;
    check("post_rst_stall", bus.stall_request, 0);
    check("post_rst_wb_ready", bus.wb_ready, 1);

    // Decode-side scoreboard vectors; busy accumulates row to row.
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.issue_valid         = vecs[i].iv;
      bus.issue_address       = vecs[i].ia;
      bus.read_address_1      = vecs[i].ra1;
      bus.read_address_2      = vecs[i].ra2;
      bus.decode_dest_address = vecs[i].dst;
      #1;
      check($sformatf("vec%0d_accept", i), bus.issue_accept, vecs[i].acc);
      check($sformatf("vec%0d_raw1", i), bus.raw_hazard_1, vecs[i].raw1);
      check($sformatf("vec%0d_raw2", i), bus.raw_hazard_2, vecs[i].raw2);
      check($sformatf("vec%0d_waw", i), bus.waw_hazard, vecs[i].waw);
    end

    // r5 result: no same-cycle bypass, commit next cycle, busy clears after the commit.
    tick(); idle();
    lu_drive(5'd5, 32'hDEADBEEF, 1'b1);
    bus.read_address_1 = 5'd5;
    #1;
    check("r5_push_lu_ready", bus.lu_ready, 1);
    check("r5_push_no_write", bus.rf_write_enable, 0);
    check("r5_push_raw1", bus.raw_hazard_1, 1);
    tick();
    bus.lu_valid      = 1'b0;
    bus.issue_valid   = 1'b1;
    bus.issue_address = 5'd5;
    #1;
    check("r5_commit_we", bus.rf_write_enable, 1);
    check("r5_commit_reissue", bus.issue_accept, 0);
    check("r5_commit_raw1", bus.raw_hazard_1, 1);
    tick();
    bus.issue_valid = 1'b0;
    #1;
    check("r5_after_raw1", bus.raw_hazard_1, 0);
    check("r5_after_we", bus.rf_write_enable, 0);

    // Issue and commit of the same register in one cycle: set wins.
    tick(); idle();
    lu_drive(5'd12, 32'hC0FFEE12, 1'b1);
    bus.read_address_1 = 5'd12;
    #1;
    check("sw_push_raw1", bus.raw_hazard_1, 0);
    tick();
    bus.lu_valid      = 1'b0;
    bus.issue_valid   = 1'b1;
    bus.issue_address = 5'd12;
    #1;
    check("sw_accept", bus.issue_accept, 1);
    check("sw_commit_we", bus.rf_write_enable, 1);
    tick();
    bus.issue_valid = 1'b0;
    #1;
    check("sw_busy_kept", bus.raw_hazard_1, 1);

    // Starvation: continuous wb blocks r7 until the drain state takes the port.
    tick(); idle();
    bus.wb_valid   = 1'b1;
    bus.wb_address = 5'd3;
    bus.wb_data    = 32'h000000A0;
    lu_drive(5'd7, 32'h77777777, 1'b1);
    #1;
    check("st0_wb_ready", bus.wb_ready, 1);
    check("st0_stall", bus.stall_request, 0);
    granted_prev = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.lu_valid = 1'b0;
      if (granted_prev) bus.wb_data = reg_data_t'(bus.wb_data + 32'd1);
      #1;
      check($sformatf("st%0d_stall", k), bus.stall_request, (k == 6) || (k == 7));
      check($sformatf("st%0d_wb_ready", k), bus.wb_ready, k != 6);
      granted_prev = (k != 6);
    end
    tick(); idle();

    // Depth-2 FIFO fills behind wb, third result waits, commits in order once wb drops.
    tick();
    bus.wb_valid   = 1'b1;
    bus.wb_address = 5'd4;
    bus.wb_data    = 32'h44;
    lu_drive(5'd10, 32'h00000A10, 1'b1);
    #1;
    check("f0_lu_ready", bus.lu_ready, 1);
    tick();
    lu_drive(5'd11, 32'h00000A11, 1'b1);
    #1;
    check("f1_lu_ready", bus.lu_ready, 1);
    tick();
    lu_drive(5'd12, 32'h00000B12, 1'b0);
    #1;
    check("f2_lu_ready_full", bus.lu_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    check("f3_lu_ready", bus.lu_ready, 0);
    check("f3_we", bus.rf_write_enable, 1);
    check("f3_addr", bus.rf_write_address, 10);
    tick();
    lu_drive(5'd12, 32'h00000B12, 1'b1);
    #1;
    check("f4_lu_ready", bus.lu_ready, 1);
    check("f4_addr", bus.rf_write_address, 11);
    tick();
    bus.lu_valid = 1'b0;
    #1;
    check("f5_addr", bus.rf_write_address, 12);
    check("f5_stall", bus.stall_request, 0);
    tick();
    #1;
    check("f6_we", bus.rf_write_enable, 0);

    // Register 0: handshakes complete, no write strobe, no busy change.
    tick(); idle();
    bus.wb_valid       = 1'b1;
    bus.wb_data        = 32'h1234;
    bus.read_address_1 = 5'd9;
    #1;
    check("z0_wb_ready", bus.wb_ready, 1);
    check("z0_we", bus.rf_write_enable, 0);
    check("z0_raw1", bus.raw_hazard_1, 1);
    tick();
    bus.wb_valid = 1'b0;
    lu_drive(5'd0, 32'h5678, 1'b1);
    #1;
    check("z1_lu_ready", bus.lu_ready, 1);
    check("z1_we", bus.rf_write_enable, 0);
    tick();
    bus.lu_valid      = 1'b0;
    bus.issue_valid   = 1'b1;
    bus.issue_address = 5'd0;
    #1;
    check("z2_we", bus.rf_write_enable, 0);
    check("z2_accept", bus.issue_accept, 1);
    tick();
    bus.issue_valid    = 1'b0;
    bus.read_address_1 = 5'd0;
    bus.read_address_2 = 5'd9;
    #1;
    check("z3_raw1", bus.raw_hazard_1, 0);
    check("z3_raw2", bus.raw_hazard_2, 1);

    // Forwarding of a writeback to a decode read port.
    tick(); idle();
    bus.wb_valid       = 1'b1;
    bus.wb_address     = 5'd3;
    bus.wb_data        = 32'h55;
    bus.read_address_2 = 5'd3;
    #1;
    check("fw_we", bus.rf_write_enable, 1);
    check("fw_valid_2", bus.fwd_valid_2, FWD_ON);
    check("fw_data_2", bus.fwd_data_2, FWD_ON ? 32'h55 : 32'h0);
    check("fw_valid_1_r0", bus.fwd_valid_1, 0);

    // Reset while the FIFO is full and the drain state is active.
    tick(); idle();
    bus.wb_valid      = 1'b1;
    bus.wb_address    = 5'd2;
    bus.wb_data       = 32'h22;
    bus.issue_valid   = 1'b1;
    bus.issue_address = 5'd20;
    lu_drive(5'd20, 32'h2020, 1'b1);
    #1;
    check("rr0_accept", bus.issue_accept, 1);
    tick();
    bus.issue_valid = 1'b0;
    lu_drive(5'd21, 32'h2121, 1'b1);
    #1;
    check("rr1_lu_ready", bus.lu_ready, 1);
    tick();
    bus.lu_valid       = 1'b0;
    bus.read_address_1 = 5'd20;
    #1;
    check("rr2_full", bus.lu_ready, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      #1;
      if (bus.stall_request) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL rr_stall_wait actual=0 expected=1");
    end
    check("rr_full_at_stall", bus.lu_ready, 0);
    check("rr_raw1_busy", bus.raw_hazard_1, 1);
    #1;
    system_reset_n = 1'b0;
    idle();
    lu_q.delete();
    #1;
    check("rr_in_reset_lu_ready", bus.lu_ready, 1);
    check("rr_in_reset_stall", bus.stall_request, 0);
    tick();
    system_reset_n     = 1'b1;
    bus.read_address_1 = 5'd20;
    #1;
    check("rr_rel_lu_ready", bus.lu_ready, 1);
    check("rr_rel_stall", bus.stall_request, 0);
    check("rr_rel_raw1", bus.raw_hazard_1, 0);
    check("rr_rel_we", bus.rf_write_enable, 0);
    tick();
    bus.issue_valid   = 1'b1;
    bus.issue_address = 5'd20;
    bus.wb_valid      = 1'b1;
    bus.wb_address    = 5'd2;
    bus.wb_data       = 32'h2222;
    #1;
    check("rr_reissue_accept", bus.issue_accept, 1);
    check("rr_wb_ready", bus.wb_ready, 1);
    tick(); idle();
    tick();

    check("lu_queue_drained", lu_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
